data_mem_arbiter: RTL and testbench

Shares the single-port data memory between the processor control unit's data path (reads and writes) and a host/loader port. The host port is used for image load, downsample-result readback and DDR staging. It accepts one transaction at a time, arbitrates between the two requesters and sequences the memory enable and read-latency wait. It returns a one-cycle ack with read data to whichever requester owns the transaction. It sits between the control unit's data-memory interface and the memory/DDR-front RAM.

---
 rtl/data_mem_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/data_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
// Contents:
//   state_t    : arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   OWNER_CPU  : owner code for the processor data path
//   OWNER_HOST : owner code for the host/loader port
//   lat_cnt_w  : width of the read-latency counter for a given RD_LAT
// Optional feature macro (consumed by rr_arb2): ARB_CPU_PRIORITY_EN
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    // The counter has to hold the value RD_LAT itself.
    function automatic int lat_cnt_w(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way requester picker (round-robin or fixed cpu priority)
// Ports:
//   req[1:0]   in  : bit 0 = cpu request, bit 1 = host request
//   last_owner in  : owner of the previous grant
//   owner      out : selected owner (OWNER_CPU / OWNER_HOST), valid when any req is high
// Macro ARB_CPU_PRIORITY_EN: defined -> cpu always wins a tie; undefined -> round-robin.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       owner
);

`ifdef ARB_CPU_PRIORITY_EN
    // last_owner is still tracked by the caller but plays no part in the decision.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        owner = OWNER_CPU;
        if (!req[0] && req[1]) begin
            owner = OWNER_HOST;
        end
    end
`else
    always_comb begin
        owner = OWNER_CPU;
        case (req)
            2'b10:   owner = OWNER_HOST;
            2'b11:   owner = ~last_owner;   // tie goes to whoever did not win last time
            default: owner = OWNER_CPU;
        endcase
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - arbitrates the single-port data memory between cpu and host
// Ports:
//   clk, rst                                   : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata       : processor data-path requester
//   host_req/we/addr/wdata, host_ack/rdata     : host/loader requester
//   mem_en/we/addr/wdata, mem_rdata            : single-port memory interface
//   busy, grant_owner                          : status (owner 0 = cpu, 1 = host)
// Parameters: ADDR_W, DATA_W, RD_LAT (1..4, cycles from mem_en to valid mem_rdata)
// Macro ARB_CPU_PRIORITY_EN selects fixed cpu priority in the picker (default round-robin).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_owner
);

    localparam int CNT_W = lat_cnt_w(RD_LAT);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("data_mem_arbiter: RD_LAT must be in 1..4");
        end
    endgenerate

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              last_owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic              arb_owner;
    logic              grant;
    logic              rd_done;

    rr_arb2 u_rr_arb2 (
        .req        ({host_req, cpu_req}),
        .last_owner (last_owner_q),
        .owner      (arb_owner)
    );

    assign grant   = (state_q == IDLE) && (cpu_req || host_req);
    // cnt_q counts WAIT cycles starting at 1, so it equals RD_LAT in cycle ISSUE+RD_LAT,
    // the cycle in which mem_rdata is valid.
    assign rd_done = (state_q == WAIT) && (cnt_q == CNT_W'(RD_LAT));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Reads always spend RD_LAT cycles in WAIT, including RD_LAT = 1,
    // so the capture edge is the end of cycle ISSUE+RD_LAT and the ack lands at
    // t0+RD_LAT+2 for every legal latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req || host_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? ACK : WAIT;
            WAIT:    if (rd_done) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction fields, owner tracking, latency counter and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWNER_CPU;
            last_owner_q <= OWNER_HOST;   // cpu wins the first tie after reset
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q      <= arb_owner;
                last_owner_q <= arb_owner;
                if (arb_owner == OWNER_HOST) begin
                    we_q    <= host_we;
                    addr_q  <= host_addr;
                    wdata_q <= host_wdata;
                end else begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end
            end

            if (state_q == ISSUE) begin
                cnt_q <= CNT_W'(1);
            end else if (state_q == WAIT && !rd_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Captured read data becomes visible together with the ack in the ACK cycle;
            // the other requester's rdata is left alone.
            if (rd_done) begin
                if (owner_q == OWNER_HOST) begin
                    host_rdata_q <= mem_rdata;
                end else begin
                    cpu_rdata_q  <= mem_rdata;
                end
            end
        end
    end

    // Outputs decoded from the registered state, so an asynchronous reset clears
    // mem_en, busy and the acks immediately.
    always_comb begin
        mem_en      = (state_q == ISSUE);
        busy        = (state_q != IDLE);
        cpu_ack     = (state_q == ACK) && (owner_q == OWNER_CPU);
        host_ack    = (state_q == ACK) && (owner_q == OWNER_HOST);
        mem_we      = we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        grant_owner = owner_q;
        cpu_rdata   = cpu_rdata_q;
        host_rdata  = host_rdata_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              grant_owner;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .grant_owner (grant_owner)
    );

    // Memory: write on mem_en&mem_we, read data valid RD_LAT cycles after the mem_en cycle,
    // random garbage in every other cycle.
    logic [DATA_W-1:0] ram  [0:65535];
    logic [DATA_W-1:0] pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    // Reference model state
    logic [DATA_W-1:0] shadow [0:65535];
    bit                model_last = 1'b1;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_pick(input bit c, input bit h, input bit last);
`ifdef ARB_CPU_PRIORITY_EN
        if (c) return 1'b0;
        if (h) return 1'b1;
        return last;
`else
        if (c && h) return !last;
        if (c) return 1'b0;
        if (h) return 1'b1;
        return last;
`endif
    endfunction

    task automatic drive(input bit who, input bit req, input bit we,
                         input logic [15:0] a, input logic [7:0] d);
        if (!who) begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            host_req = req; host_we = we; host_addr = a; host_wdata = d;
        end
    endtask

    task automatic new_fields(input bit reads_only, output bit we,
                              output logic [15:0] a, output logic [7:0] d);
        we = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
        a  = 16'h0100 + 16'($urandom_range(0, 7));
        d  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        #1;
        check("rst_mem_en",  32'(mem_en), 32'(0));
        check("rst_busy",    32'(busy), 32'(0));
        check("rst_acks",    32'({cpu_ack, host_ack}), 32'(0));
        check("rst_owner",   32'(grant_owner), 32'(0));
        check("rst_rdata",   32'({cpu_rdata, host_rdata}), 32'(0));
        check("rst_memflds", 32'({mem_we, mem_addr, mem_wdata}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        model_last = 1'b1;
    endtask

    // One transaction from a single requester, starting in IDLE.
    task automatic txn(input bit who, input bit we, input logic [15:0] a,
                       input logic [7:0] d, input bit drop_early, input string tag);
        int cyc = 0;
        int en_cnt = 0;
        int lat = 0;
        bit got = 1'b0;
        bit other_ack = 1'b0;
        logic [7:0] other_before;
        logic [7:0] own_rd;
        other_before = who ? cpu_rdata : host_rdata;
        drive(who, 1'b1, we, a, d);
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_en) begin
                en_cnt++;
                check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
                check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
                if (we) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d));
            end
            if (cyc == 1) begin
                check({tag, "_grant"}, 32'({busy, grant_owner}), 32'({1'b1, who}));
                // Fields scrambled after the grant must not affect the transaction.
                drive(who, !drop_early, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
            end
            if (who ? cpu_ack : host_ack) other_ack = 1'b1;
            if (who ? host_ack : cpu_ack) begin
                got = 1'b1;
                lat = cyc;
                drive(who, 1'b0, 1'b0, 16'h0, 8'h0);
                own_rd = who ? host_rdata : cpu_rdata;
                if (!we) check({tag, "_rdata"}, 32'(own_rd), 32'(shadow[a]));
            end
        end
        check({tag, "_ack_seen"}, 32'(got), 32'(1));
        check({tag, "_latency"}, 32'(lat), we ? 32'(2) : 32'(RD_LAT + 2));
        check({tag, "_mem_en_cnt"}, 32'(en_cnt), 32'(1));
        check({tag, "_other_ack"}, 32'(other_ack), 32'(0));
        check({tag, "_other_rdata"}, 32'(who ? cpu_rdata : host_rdata), 32'(other_before));
        if (we) shadow[a] = d;
        model_last = who;
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    // Both requesters hold req high until they have completed nc / nh transactions.
    task automatic contend(input int nc, input int nh, input bit reads_only, input string tag);
        int rc = nc;
        int rh = nh;
        int en_cnt = 0;
        int cyc = 0;
        bit who;
        bit ew;
        bit c_we, h_we;
        logic [15:0] c_a, h_a;
        logic [7:0]  c_d, h_d;
        new_fields(reads_only, c_we, c_a, c_d);
        new_fields(reads_only, h_we, h_a, h_d);
        drive(1'b0, rc > 0, c_we, c_a, c_d);
        drive(1'b1, rh > 0, h_we, h_a, h_d);
        while ((rc > 0 || rh > 0) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_en) en_cnt++;
            if (cpu_ack || host_ack) begin
                check({tag, "_single_ack"}, 32'(cpu_ack & host_ack), 32'(0));
                who = host_ack;
                ew  = exp_pick(rc > 0, rh > 0, model_last);
                check({tag, "_order"}, 32'(who), 32'(ew));
                check({tag, "_grant_owner"}, 32'(grant_owner), 32'(who));
                check({tag, "_mem_en_cnt"}, 32'(en_cnt), 32'(1));
                en_cnt = 0;
                model_last = who;
                if (!who) begin
                    if (c_we) shadow[c_a] = c_d;
                    else check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(shadow[c_a]));
                    rc--;
                    new_fields(reads_only, c_we, c_a, c_d);
                    drive(1'b0, rc > 0, c_we, c_a, c_d);
                end else begin
                    if (h_we) shadow[h_a] = h_d;
                    else check({tag, "_host_rdata"}, 32'(host_rdata), 32'(shadow[h_a]));
                    rh--;
                    new_fields(reads_only, h_we, h_a, h_d);
                    drive(1'b1, rh > 0, h_we, h_a, h_d);
                end
            end
        end
        check({tag, "_all_done"}, 32'(rc + rh), 32'(0));
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int acks;
        do_reset();

        // Directed: cpu write then readback
        txn(1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, "t1_wr");
        txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, "t1_rd");
        check("t1_rdata_const", 32'(cpu_rdata), 32'h0000_00A5);

        // Host-only writes then readback
        for (int i = 0; i < 8; i++) txn(1'b1, 1'b1, 16'h0100 + 16'(i), 8'(i + 1), 1'b0, "t4_wr");
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 1'b0, 16'h0100 + 16'(i), 8'h00, 1'b0, "t4_rd");
            check("t4_rdata_const", 32'(host_rdata), 32'(i + 1));
        end
        check("t4_cpu_rdata_kept", 32'(cpu_rdata), 32'h0000_00A5);

        // Simultaneous first requests after reset
        do_reset();
        contend(1, 1, 1'b1, "t2");

        // Continuous contention
        contend(4, 4, 1'b0, "t3");

        // Reset during WAIT of a host read
        drive(1'b1, 1'b1, 1'b0, 16'h0105, 8'h00);
        @(posedge clk); #1;
        check("t5_issue", 32'(mem_en), 32'(1));
        @(posedge clk); #1;
        check("t5_wait_busy", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        check("t5_abort_mem_en", 32'(mem_en), 32'(0));
        check("t5_abort_busy", 32'(busy), 32'(0));
        check("t5_abort_acks", 32'({cpu_ack, host_ack}), 32'(0));
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_last = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (host_ack || cpu_ack) acks++;
        end
        check("t5_no_ack_after_reset", 32'(acks), 32'(0));
        contend(1, 1, 1'b1, "t5_rr");

        // Requester drops req right after the grant
        txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, "t6");

        // Randomized single transactions and contention bursts
        for (int i = 0; i < 24; i++) begin
            bit w, wh;
            logic [15:0] a;
            logic [7:0]  d;
            new_fields(1'b0, w, a, d);
            wh = 1'($urandom_range(0, 1));
            txn(wh, w, a, d, 1'($urandom_range(0, 1)), "rnd");
        end
        contend(3, 2, 1'b0, "rnd_c1");
        contend(2, 5, 1'b0, "rnd_c2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
